// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM encoding and address helper for the MIPS IF stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        HOLD    = 2'b01,
        DISCARD = 2'b10
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux: jr > jump > branch > pc+4, result always word aligned.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module next_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_plus_four,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic [31:0] next_pc
);

    assign redirect = jr | jump | branch_taken;

    always_comb begin
        redirect_target = word_align(branch_target);
        if (jump) redirect_target = word_align(jump_target);
        if (jr)   redirect_target = word_align(jr_target);
        next_pc = redirect ? redirect_target : pc_plus_four;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem requests, presents one word per cycle to IF/ID.
// Latency: word valid in the cycle imem_ready returns it, no extra register stage.
// Backpressure: stall_F parks the returned word in hold_buf and stops requesting.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        branch_taken_D,
    input  logic        jump_D,
    input  logic        jr_D,
    input  logic [31:0] branch_target_D,
    input  logic [31:0] jump_target_D,
    input  logic [31:0] jr_target_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] pc_plus_four_F,
    output logic [31:0] instruction_F,
    output logic        fetch_valid_F
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  hold_buf_q, hold_buf_d;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic [31:0]  next_pc;

    assign pc_F           = pc_q;
    assign pc_plus_four_F = pc_q + 32'd4;
    assign imem_addr      = pc_q;

    next_pc_sel u_next_pc_sel (
        .pc_plus_four    (pc_plus_four_F),
        .branch_taken    (branch_taken_D),
        .jump            (jump_D),
        .jr              (jr_D),
        .branch_target   (branch_target_D),
        .jump_target     (jump_target_D),
        .jr_target       (jr_target_D),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .next_pc         (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        hold_buf_d    = hold_buf_q;
        imem_req      = 1'b0;
        fetch_valid_F = 1'b0;
        instruction_F = NOP_INSTR;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        // A redirect kills the word in flight; if it has not returned yet
                        // the request must still complete, so remember where to go.
                        if (imem_ready) begin
                            pc_d = next_pc;
                        end else begin
                            redirect_pc_d = redirect_target;
                            state_d       = DISCARD;
                        end
                    end else if (imem_ready) begin
                        fetch_valid_F = 1'b1;
                        instruction_F = imem_rdata;
                        if (stall_F) begin
                            hold_buf_d = imem_rdata;
                            state_d    = HOLD;
                        end else begin
                            pc_d = next_pc;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end else begin
                        fetch_valid_F = 1'b1;
                        instruction_F = hold_buf_q;
                        if (!stall_F) begin
                            pc_d    = next_pc;
                            state_d = FETCH;
                        end
                    end
                end
                DISCARD: begin
                    imem_req = 1'b1;
                    if (redirect) redirect_pc_d = redirect_target;
                    if (imem_ready) begin
                        pc_d    = redirect ? redirect_target : redirect_pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= word_align(RESET_PC);
            redirect_pc_q <= 32'h0;
            hold_buf_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            hold_buf_q    <= hold_buf_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios then random traffic, every cycle checked against a fetch-stream model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_F;
    logic        branch_taken_D, jump_D, jr_D;
    logic [31:0] branch_target_D, jump_target_D, jr_target_D;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_F, pc_plus_four_F, instruction_F;
    logic        fetch_valid_F;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Model: the PC the pipeline should see next, whether a word is parked
    // for a stalled decode, and whether the outstanding imem request is stale.
    logic [31:0] m_exp_pc;
    logic        m_holding;
    logic [31:0] m_hold_word;
    logic        m_poisoned;
    logic        m_prev_wait;
    logic [31:0] m_prev_addr;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall_F         (stall_F),
        .branch_taken_D  (branch_taken_D),
        .jump_D          (jump_D),
        .jr_D            (jr_D),
        .branch_target_D (branch_target_D),
        .jump_target_D   (jump_target_D),
        .jr_target_D     (jr_target_D),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .pc_F            (pc_F),
        .pc_plus_four_F  (pc_plus_four_F),
        .instruction_F   (instruction_F),
        .fetch_valid_F   (fetch_valid_F)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        stall_F        = 1'b0;
        branch_taken_D = 1'b0;
        jump_D         = 1'b0;
        jr_D           = 1'b0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'h0;
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        logic        exp_req, exp_valid;
        logic [31:0] exp_instr;
        if (reset) begin
            chk1("rst_req", imem_req, 1'b0);
            chk1("rst_valid", fetch_valid_F, 1'b0);
            chk("rst_instr", instruction_F, NOP_INSTR_DEF);
            m_exp_pc    = RESET_PC_DEF;
            m_holding   = 1'b0;
            m_poisoned  = 1'b0;
            m_prev_wait = 1'b0;
        end else begin
            redir = jr_D | jump_D | branch_taken_D;
            tgt   = jr_D ? jr_target_D : (jump_D ? jump_target_D : branch_target_D);
            tgt   = {tgt[31:2], 2'b00};
            exp_req   = !m_holding;
            exp_valid = !redir && (m_holding || (imem_ready && !m_poisoned));
            exp_instr = !exp_valid ? NOP_INSTR_DEF : (m_holding ? m_hold_word : imem_rdata);

            chk1("m_req", imem_req, exp_req);
            chk1("m_valid", fetch_valid_F, exp_valid);
            chk("m_instr", instruction_F, exp_instr);
            chk("m_pc4", pc_plus_four_F, pc_F + 32'd4);
            chk("m_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (!m_poisoned) chk("m_pc", pc_F, m_exp_pc);
            if (!m_holding && !m_poisoned) chk("m_addr", imem_addr, m_exp_pc);
            if (m_prev_wait) chk("m_addr_hold", imem_addr, m_prev_addr);

            m_prev_wait = exp_req && !imem_ready;
            m_prev_addr = imem_addr;
            if (redir) begin
                m_exp_pc  = tgt;
                m_holding = 1'b0;
                if (exp_req) m_poisoned = !imem_ready;
            end else if (m_holding) begin
                if (!stall_F) begin
                    m_holding = 1'b0;
                    m_exp_pc  = m_exp_pc + 32'd4;
                end
            end else if (imem_ready) begin
                if (m_poisoned) begin
                    m_poisoned = 1'b0;
                end else if (stall_F) begin
                    m_holding   = 1'b1;
                    m_hold_word = imem_rdata;
                end else begin
                    m_exp_pc = m_exp_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic adv();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_inputs();
        #1;
        adv();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr_inputs();
        branch_target_D = 32'h0;
        jump_target_D   = 32'h0;
        jr_target_D     = 32'h0;
        m_exp_pc    = RESET_PC_DEF;
        m_holding   = 1'b0;
        m_hold_word = 32'h0;
        m_poisoned  = 1'b0;
        m_prev_wait = 1'b0;
        m_prev_addr = 32'h0;
        @(posedge clock);
        #1;
        do_reset();

        // Zero-wait memory: one word per cycle
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'h1000_0000 + 32'(i);
            #1;
            chk("t1_addr", imem_addr, 32'h0040_0000 + 32'(4 * i));
            chk1("t1_valid", fetch_valid_F, 1'b1);
            if (i == 0) chk("t1_pc4", pc_plus_four_F, 32'h0040_0004);
            adv();
        end

        // Two wait states before the first word
        do_reset();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_addr", imem_addr, 32'h0040_0000);
            chk1("t2_valid", fetch_valid_F, 1'b0);
            chk("t2_instr", instruction_F, 32'h0);
            adv();
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h2008_0005;
        #1;
        chk1("t2_valid_rdy", fetch_valid_F, 1'b1);
        chk("t2_instr_rdy", instruction_F, 32'h2008_0005);
        adv();
        imem_ready = 1'b0;
        #1;
        chk("t2_next_addr", imem_addr, 32'h0040_0004);
        adv();

        // Stall while the word arrives
        imem_ready = 1'b1;
        imem_rdata = 32'h8C09_0004;
        stall_F    = 1'b1;
        #1;
        chk1("t3_valid_arr", fetch_valid_F, 1'b1);
        adv();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        #1;
        chk1("t3_req", imem_req, 1'b0);
        chk("t3_instr", instruction_F, 32'h8C09_0004);
        chk("t3_pc", pc_F, 32'h0040_0004);
        adv();
        stall_F = 1'b0;
        #1;
        chk1("t3_valid_rel", fetch_valid_F, 1'b1);
        chk("t3_instr_rel", instruction_F, 32'h8C09_0004);
        adv();
        #1;
        chk("t3_next_addr", imem_addr, 32'h0040_0008);
        chk1("t3_req_back", imem_req, 1'b1);
        adv();
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_1111;
        #1;
        adv();

        // Branch redirect with a misaligned target
        branch_taken_D  = 1'b1;
        branch_target_D = 32'h0040_0043;
        imem_rdata      = 32'h2222_2222;
        #1;
        chk1("t4_valid", fetch_valid_F, 1'b0);
        adv();
        branch_taken_D = 1'b0;
        imem_ready     = 1'b0;
        #1;
        chk("t4_addr", imem_addr, 32'h0040_0040);
        adv();

        // Jump while the request is outstanding: the late word is dropped
        jump_D        = 1'b1;
        jump_target_D = 32'h0040_0100;
        #1;
        chk1("t5_valid_jmp", fetch_valid_F, 1'b0);
        adv();
        jump_D = 1'b0;
        #1;
        chk("t5_addr_held", imem_addr, 32'h0040_0040);
        chk1("t5_valid_wait", fetch_valid_F, 1'b0);
        adv();
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("t5_valid_dead", fetch_valid_F, 1'b0);
        adv();
        imem_ready = 1'b0;
        #1;
        chk("t5_addr", imem_addr, 32'h0040_0100);
        adv();

        // jr beats branch; reset abandons a discarding request
        imem_ready      = 1'b1;
        imem_rdata      = 32'h3333_3333;
        jr_D            = 1'b1;
        jr_target_D     = 32'h0040_0200;
        branch_taken_D  = 1'b1;
        branch_target_D = 32'h0040_0300;
        #1;
        adv();
        clr_inputs();
        #1;
        chk("t6_jr_wins", imem_addr, 32'h0040_0200);
        adv();
        jump_D        = 1'b1;
        jump_target_D = 32'h0040_0500;
        #1;
        adv();
        jump_D = 1'b0;
        reset  = 1'b1;
        #1;
        chk1("t6_req_rst", imem_req, 1'b0);
        adv();
        reset = 1'b0;
        #1;
        chk("t6_addr_after", imem_addr, 32'h0040_0000);
        adv();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 199) == 0);
            imem_ready      = ($urandom_range(0, 9) < 6);
            imem_rdata      = $urandom();
            stall_F         = ($urandom_range(0, 3) == 0);
            branch_taken_D  = ($urandom_range(0, 11) == 0);
            jump_D          = ($urandom_range(0, 15) == 0);
            jr_D            = ($urandom_range(0, 19) == 0);
            branch_target_D = $urandom();
            jump_target_D   = $urandom();
            jr_target_D     = $urandom();
            #1;
            adv();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
